// File: rtl/execute_unit_mc.sv
// execute_unit_mc: multi-cycle RISC-V execute unit (ALU, shift-add multiplier, optional restoring divider).
// Latency: ALU ops 1 cycle; MUL/MULHU XLEN/MUL_BITS_PER_CYCLE+1; divide XLEN+1 (special cases 1).
// Backpressure: in_ready only in IDLE with the output slot free or draining; result holds while !out_ready.
// Optional divider: define EXE_DIV_EN to build the DIV state and datapath; otherwise ops 12..15 return 0.
module execute_unit_mc #(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1,
    parameter int TAG_W              = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int SH_W      = $clog2(XLEN);
    localparam int CNT_W     = $clog2(XLEN) + 1;
    localparam int MUL_ITERS = XLEN / MUL_BITS_PER_CYCLE;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS - 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        MUL
`ifdef EXE_DIV_EN
        , DIV
`endif
    } state_t;

    state_t              state_q;
    logic                out_valid_q;
    logic [XLEN-1:0]     out_result_q;
    logic [TAG_W-1:0]    out_tag_q;
    logic [3:0]          op_q;
    logic [TAG_W-1:0]    tag_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     mplr_q;

    logic                accept;
    logic                is_mul_op;
    logic [SH_W-1:0]     shamt;
    logic [XLEN-1:0]     alu_result;
    logic [XLEN-1:0]     imm_result;
    logic [2*XLEN-1:0]   prod_d;

`ifdef EXE_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN-1:0]     quo_q;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     dvsr_q;
    logic                neg_quo_q;
    logic                neg_rem_q;

    logic                is_div_op;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic                div_by_zero;
    logic                div_ovf;
    logic                div_special;
    logic [XLEN-1:0]     div_spec_result;
    logic [XLEN:0]       div_shifted;
    logic [XLEN:0]       div_diff;
    logic [XLEN-1:0]     quo_d;
    logic [XLEN-1:0]     rem_d;
    logic [XLEN-1:0]     div_final;
`endif

    assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q != IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign is_mul_op  = (in_op == OP_MUL) || (in_op == OP_MULHU);
    assign shamt      = in_b[SH_W-1:0];

    // Single-cycle ALU result for the offered op.
    always_comb begin
        alu_result = '0;
        case (in_op)
            OP_ADD:  alu_result = in_a + in_b;
            OP_SUB:  alu_result = in_a - in_b;
            OP_SLL:  alu_result = in_a << shamt;
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, in_a < in_b};
            OP_XOR:  alu_result = in_a ^ in_b;
            OP_SRL:  alu_result = in_a >> shamt;
            OP_SRA:  alu_result = $signed(in_a) >>> shamt;
            OP_OR:   alu_result = in_a | in_b;
            OP_AND:  alu_result = in_a & in_b;
            default: alu_result = '0;
        endcase
    end

    // Next partial product: add shifted multiplicand for each multiplier bit retired this cycle.
    always_comb begin
        prod_d = prod_q;
        for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
            if (mplr_q[i]) begin
                prod_d = prod_d + (mcand_q << i);
            end
        end
    end

`ifdef EXE_DIV_EN
    // Divider operand conditioning, special cases and one restoring step.
    always_comb begin
        is_div_op       = (in_op[3:2] == 2'b11);
        a_neg           = !in_op[0] && in_a[XLEN-1];
        b_neg           = !in_op[0] && in_b[XLEN-1];
        a_mag           = a_neg ? -in_a : in_a;
        b_mag           = b_neg ? -in_b : in_b;
        div_by_zero     = (in_b == '0);
        div_ovf         = !in_op[0] && (in_a == MIN_NEG) && (in_b == '1);
        div_special     = div_by_zero || div_ovf;
        if (in_op[1]) begin
            div_spec_result = div_by_zero ? in_a : '0;
        end else begin
            div_spec_result = div_by_zero ? '1 : in_a;
        end
        div_shifted = {rem_q, quo_q[XLEN-1]};
        div_diff    = div_shifted - {1'b0, dvsr_q};
        if (!div_diff[XLEN]) begin
            rem_d = div_diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = div_shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (op_q[1]) begin
            div_final = neg_rem_q ? -rem_d : rem_d;
        end else begin
            div_final = neg_quo_q ? -quo_d : quo_d;
        end
    end
`endif

    // Result for ops that finish in one cycle (ALU and divide-class fast paths).
    always_comb begin
        imm_result = alu_result;
`ifdef EXE_DIV_EN
        if (is_div_op) begin
            imm_result = div_spec_result;
        end
`else
        if (in_op[3:2] == 2'b11) begin
            imm_result = '0;
        end
`endif
    end

    // Control FSM with registered result slot and iterative datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            op_q         <= '0;
            tag_q        <= '0;
            cnt_q        <= '0;
            prod_q       <= '0;
            mcand_q      <= '0;
            mplr_q       <= '0;
`ifdef EXE_DIV_EN
            quo_q        <= '0;
            rem_q        <= '0;
            dvsr_q       <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= in_op;
                        tag_q <= in_tag;
                        cnt_q <= '0;
                        if (is_mul_op) begin
                            state_q <= MUL;
                            prod_q  <= '0;
                            mcand_q <= {{XLEN{1'b0}}, in_a};
                            mplr_q  <= in_b;
                        end
`ifdef EXE_DIV_EN
                        else if (is_div_op && !div_special) begin
                            state_q   <= DIV;
                            quo_q     <= a_mag;
                            rem_q     <= '0;
                            dvsr_q    <= b_mag;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                        end
`endif
                        else begin
                            out_valid_q  <= 1'b1;
                            out_result_q <= imm_result;
                            out_tag_q    <= in_tag;
                        end
                    end
                end
                MUL: begin
                    prod_q  <= prod_d;
                    mcand_q <= mcand_q << MUL_BITS_PER_CYCLE;
                    mplr_q  <= mplr_q >> MUL_BITS_PER_CYCLE;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == MUL_LAST) begin
                        state_q      <= IDLE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= (op_q == OP_MUL) ? prod_d[XLEN-1:0] : prod_d[2*XLEN-1:XLEN];
                        out_tag_q    <= tag_q;
                    end
                end
`ifdef EXE_DIV_EN
                DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == DIV_LAST) begin
                        state_q      <= IDLE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= div_final;
                        out_tag_q    <= tag_q;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_unit_mc.sv
// tb_execute_unit_mc: directed vectors for execute_unit_mc with a transaction-level reference model.
// Model predicts result, tag and arrival cycle of each accepted op; outputs are compared every cycle.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_execute_unit_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int busy_end = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    execute_unit_mc #(.XLEN(32), .MUL_BITS_PER_CYCLE(1), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference result from the instruction semantics.
    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        logic [31:0] q, r;
        p  = {32'b0, a} * {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << b[4:0];
            4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> b[4:0];
            4'd7:  return 32'($signed(a) >>> b[4:0]);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            default: begin
`ifdef EXE_DIV_EN
                if (b == 32'd0) begin
                    q = 32'hFFFFFFFF;
                    r = a;
                end else if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    q = a;
                    r = 32'd0;
                end else if (!op[0]) begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end else begin
                    q = a / b;
                    r = a % b;
                end
                return op[1] ? r : q;
`else
                q = a;
                r = b;
                return (q & 32'd0) | (r & 32'd0);
`endif
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 4'd10 || op == 4'd11) return 33;
`ifdef EXE_DIV_EN
        if (op >= 4'd12) begin
            if (b == 32'd0) return 1;
            if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
            return 33;
        end
`endif
        return 1;
    endfunction

    // Transaction monitor: records accepted ops into the model, retires handshaken results.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            busy_end = 0;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_t e;
                int   lat;
                lat   = model_lat(in_op, in_a, in_b);
                e.res = model_res(in_op, in_a, in_b);
                e.tag = in_tag;
                e.due = cyc + lat - 1;
                exp_q.push_back(e);
                if (lat > 1) busy_end = cyc + lat - 1;
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_busy;
            exp_busy = (cyc < busy_end);
            chk("busy", busy, exp_busy);
            chk("in_ready", in_ready, !exp_busy && (!out_valid || out_ready));
            if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
                chk("out_valid", out_valid, 1'b1);
                chk("out_result", out_result, exp_q[0].res);
                chk("out_tag", out_tag, exp_q[0].tag);
            end else begin
                chk("out_valid_idle", out_valid, 1'b0);
            end
        end
    end

    // Offer one op and wait for its handshake; returns 1 time unit after the accept edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        bit ok;
        bit done;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        done     = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            done = ok;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the next result, checking value, tag, latency and busy-cycle count.
    task automatic expect_out(input string name, input logic [31:0] res, input logic [4:0] tag,
                              input int lat, input int bcnt);
        int  n;
        int  bc;
        bit  seen;
        n = 0;
        bc = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
            if (out_valid) seen = 1'b1;
        end
        chk({name, "_lat"}, n, lat);
        chk(name, out_result, res);
        chk({name, "_tag"}, out_tag, tag);
        chk({name, "_busycycles"}, bc, bcnt);
    endtask

    initial begin
        int vcnt;
        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", out_tag, 5'd0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-cycle ALU ops with literal expectations
        send(4'd0, 32'h7FFFFFFF, 32'h1, 5'd3);
        expect_out("add_wrap", 32'h80000000, 5'd3, 1, 0);
        send(4'd7, 32'hF0000000, 32'h24, 5'd4);
        expect_out("sra", 32'hFF000000, 5'd4, 1, 0);
        send(4'd3, 32'hFFFFFFFF, 32'h1, 5'd5);
        expect_out("slt", 32'h1, 5'd5, 1, 0);
        send(4'd4, 32'hFFFFFFFF, 32'h1, 5'd6);
        expect_out("sltu", 32'h0, 5'd6, 1, 0);

        // Back-to-back burst of every ALU op, model-checked
        for (int op = 0; op < 10; op++) begin
            send(4'(op), 32'hA5A5_0F0F, 32'h0000_0013, 5'(op));
            send(4'(op), 32'h8000_0001, 32'hFFFF_FFE1, 5'(op + 10));
        end
        @(posedge clk);
        #1;

        // Multiplier
        send(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11);
        expect_out("mul", 32'h00000001, 5'd11, 33, 32);
        @(posedge clk);
        #1;
        send(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12);
        expect_out("mulhu", 32'hFFFFFFFE, 5'd12, 33, 32);
        @(posedge clk);
        #1;
        send(4'd10, 32'h12345678, 32'h9ABCDEF0, 5'd13);
        send(4'd11, 32'h12345678, 32'h9ABCDEF0, 5'd14);

        // Divide-class ops
`ifdef EXE_DIV_EN
        send(4'd12, 32'hFFFFFFF9, 32'h2, 5'd15);
        expect_out("div_neg", 32'hFFFFFFFD, 5'd15, 33, 32);
        @(posedge clk);
        #1;
        send(4'd14, 32'hFFFFFFF9, 32'h2, 5'd16);
        expect_out("rem_neg", 32'hFFFFFFFF, 5'd16, 33, 32);
        @(posedge clk);
        #1;
        send(4'd13, 32'h5, 32'h0, 5'd17);
        expect_out("divu_zero", 32'hFFFFFFFF, 5'd17, 1, 0);
        send(4'd12, 32'h80000000, 32'hFFFFFFFF, 5'd18);
        expect_out("div_ovf", 32'h80000000, 5'd18, 1, 0);
        send(4'd15, 32'd100, 32'd7, 5'd19);
        send(4'd14, 32'h80000000, 32'hFFFFFFFF, 5'd20);
        send(4'd14, 32'd9, 32'd0, 5'd21);
`else
        send(4'd12, 32'hFFFFFFF9, 32'h2, 5'd15);
        expect_out("div_off", 32'h0, 5'd15, 1, 0);
        send(4'd15, 32'd100, 32'd7, 5'd19);
        expect_out("remu_off", 32'h0, 5'd19, 1, 0);
`endif
        @(posedge clk);
        #1;

        // Backpressure: result held, next op waits, accepted the cycle out_ready returns
        out_ready = 1'b0;
        send(4'd0, 32'd1, 32'd2, 5'd7);
        expect_out("bp_add", 32'd3, 5'd7, 1, 0);
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_a     = 32'd5;
        in_b     = 32'd6;
        in_tag   = 5'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_result", out_result, 32'd3);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", out_valid, 1'b1);
        chk("bp_next_result", out_result, 32'd11);
        chk("bp_next_tag", out_tag, 5'd9);
        @(posedge clk);
        #1;

        // Reset during MUL iteration 10 abandons the op
        send(4'd10, 32'd3, 32'd5, 5'd22);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_out_valid", out_valid, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_in_ready", in_ready, 1'b1);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("rstmid_no_stale", vcnt, 0);
        @(posedge clk);
        #1;
        send(4'd9, 32'hFF00FF00, 32'h0F0F0F0F, 5'd23);
        expect_out("after_rst_and", 32'h0F000F00, 5'd23, 1, 0);

        // Drain
        vcnt = 0;
        while (exp_q.size() > 0 && vcnt < 200) begin
            @(posedge clk);
            vcnt++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 64'd0, 64'd1);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
